// File: rtl/grom_bus_target.sv
// rtl/grom_bus_target.sv - grom CPU bus responder: byte RAM, TX FIFO, RX holding register, status and fetch counter ports
module grom_bus_target #(
    parameter int    RAM_DEPTH  = 4096,
    parameter string MEM_INIT   = "",
    parameter int    FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] addr,
    input  logic [7:0]  data_out,
    input  logic        we,
    input  logic        ioreq,
    input  logic        m1,
    output logic [7:0]  data_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int          AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int          FW        = $clog2(FIFO_DEPTH);
    localparam logic [12:0] RAM_LIMIT = RAM_DEPTH[12:0];
    localparam logic [FW:0] FIFO_FULL = FIFO_DEPTH[FW:0];

    localparam logic [7:0] PORT_STATUS = 8'h00;
    localparam logic [7:0] PORT_RX     = 8'h01;
    localparam logic [7:0] PORT_CNT_LO = 8'h02;
    localparam logic [7:0] PORT_CNT_HI = 8'h03;

    logic [7:0] ram [1 << AW];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [7:0]    data_in_q,   data_in_d;
    logic [FW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [FW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [FW:0]   count_q,     count_d;
    logic          overflow_q,  overflow_d;
    logic          rx_full_q,   rx_full_d;
    logic [7:0]    rx_hold_q,   rx_hold_d;
    logic [15:0]   fetch_cnt_q, fetch_cnt_d;
    logic [7:0]    shadow_q,    shadow_d;
    logic [13:0]   acc_key_q,   acc_key_d;
    logic          trk_valid_q, trk_valid_d;

    logic [7:0]  io_port;
    logic [13:0] acc_key;
    logic        acc_start, mem_hit, mem_we, io_rd, io_wr;
    logic        fifo_empty, fifo_full, push, pop, push_ok, push_drop;
    logic        status_clr, rx_pop, rx_capture, snap;

    // An access is one run of cycles with an unchanged {ioreq, we, addr}; side effects fire once per run.
    assign io_port    = addr[7:0];
    assign acc_key    = {ioreq, we, addr};
    assign acc_start  = ~trk_valid_q | (acc_key != acc_key_q);
    assign mem_hit    = ({1'b0, addr} < RAM_LIMIT);
    assign mem_we     = ~ioreq & we & mem_hit;
    assign io_rd      = ioreq & ~we;
    assign io_wr      = ioreq & we;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    assign push       = io_wr & (io_port == PORT_STATUS);
    assign pop        = ~fifo_empty & tx_ready;
    assign push_ok    = push & (~fifo_full | pop);
    assign push_drop  = push & fifo_full & ~pop;

    assign status_clr = acc_start & io_rd & (io_port == PORT_STATUS);
    assign rx_pop     = acc_start & io_rd & (io_port == PORT_RX) & rx_full_q;
    assign snap       = acc_start & io_rd & (io_port == PORT_CNT_LO);
    assign rx_capture = rx_valid & ~rx_full_q;

    always_comb begin
        data_in_d   = 8'h00;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        rx_full_d   = rx_full_q;
        rx_hold_d   = rx_hold_q;
        fetch_cnt_d = fetch_cnt_q;
        shadow_d    = shadow_q;
        acc_key_d   = acc_key;
        trk_valid_d = 1'b1;

        // RAM is read asynchronously here so a same-cycle write still returns the old byte.
        if (!ioreq) begin
            data_in_d = mem_hit ? ram[addr[AW-1:0]] : 8'h00;
        end else begin
            case (io_port)
                PORT_STATUS: data_in_d = {4'b0000, rx_full_q, overflow_q, fifo_full, fifo_empty};
                PORT_RX:     data_in_d = rx_full_q ? rx_hold_q : 8'h00;
                PORT_CNT_LO: data_in_d = fetch_cnt_q[7:0];
                PORT_CNT_HI: data_in_d = shadow_q;
                default:     data_in_d = 8'hFF;
            endcase
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The clear is applied before the set so a drop in the same cycle is never lost.
        if (status_clr) begin
            overflow_d = 1'b0;
        end
        if (push_drop) begin
            overflow_d = 1'b1;
        end

        if (rx_capture) begin
            rx_full_d = 1'b1;
            rx_hold_d = rx_data;
        end
        if (rx_pop) begin
            rx_full_d = 1'b0;
        end

        if (m1) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
        if (snap) begin
            shadow_d = fetch_cnt_q[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            ram[addr[AW-1:0]] <= data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= data_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_in_q   <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            rx_full_q   <= 1'b0;
            rx_hold_q   <= 8'h00;
            fetch_cnt_q <= 16'h0000;
            shadow_q    <= 8'h00;
            acc_key_q   <= '0;
            trk_valid_q <= 1'b0;
        end else begin
            data_in_q   <= data_in_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            rx_full_q   <= rx_full_d;
            rx_hold_q   <= rx_hold_d;
            fetch_cnt_q <= fetch_cnt_d;
            shadow_q    <= shadow_d;
            acc_key_q   <= acc_key_d;
            trk_valid_q <= trk_valid_d;
        end
    end

    // Storage is not reset, so the head byte is masked while the FIFO is empty.
    assign data_in  = data_in_q;
    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
    assign rx_ready = ~rx_full_q;

endmodule

// File: tb/tb_grom_bus_target.sv
// tb/tb_grom_bus_target.sv - scoreboard bench for grom_bus_target
module tb_grom_bus_target;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr;
    logic [7:0]  data_out;
    logic        we, ioreq, m1;
    logic [7:0]  data_in, tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;

    int n_vec = 0;
    int n_err = 0;
    int n_pops = 0;
    logic [7:0] rd_exp[$];
    logic [7:0] tx_exp[$];

    grom_bus_target #(.RAM_DEPTH(3072), .MEM_INIT(""), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(rst_n), .addr(addr), .data_out(data_out), .we(we),
        .ioreq(ioreq), .m1(m1), .data_in(data_in), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic io, input logic w, input logic [11:0] a, input logic [7:0] d);
        ioreq = io; we = w; addr = a; data_out = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    task automatic rd(input string tag, input logic io, input logic [11:0] a, input logic [7:0] exp);
        rd_exp.push_back(exp);
        cycle(io, 1'b0, a, 8'h00);
        chk(tag, {8'h00, data_in}, {8'h00, rd_exp.pop_front()});
    endtask

    // TX consumer side: every accepted byte must be the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            n_pops++;
            if (tx_exp.size() == 0) chk("tx_unexpected", {15'h0, tx_valid}, 16'h0000);
            else chk("tx_data", {8'h00, tx_data}, {8'h00, tx_exp.pop_front()});
        end
    end

    initial begin
        int base;
        rst_n = 1'b0; addr = '0; data_out = '0; we = 0; ioreq = 0; m1 = 0;
        tx_ready = 0; rx_data = '0; rx_valid = 0;
        #12;
        chk("rst_data_in", {8'h00, data_in}, 16'h0000);
        chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        chk("rst_tx_data", {8'h00, tx_data}, 16'h0000);
        #10 rst_n = 1'b1;
        chk("rst_rx_ready", {15'h0, rx_ready}, 16'h0001);
        @(posedge clk); #1;
        rd("rst_status", 1'b1, 12'h000, 8'h01);
        rd("rst_cnt_lo", 1'b1, 12'h002, 8'h00);
        rd("rst_shadow", 1'b1, 12'h003, 8'h00);

        // 1: RAM write, held read, read-before-write, unmapped
        cycle(1'b0, 1'b1, 12'h123, 8'h5A);
        cycle(1'b0, 1'b0, 12'h123, 8'h00);
        rd("mem_hold", 1'b0, 12'h123, 8'h5A);
        rd_exp.push_back(8'h5A);
        cycle(1'b0, 1'b1, 12'h123, 8'h77);
        chk("mem_rbw", {8'h00, data_in}, {8'h00, rd_exp.pop_front()});
        rd("mem_new", 1'b0, 12'h123, 8'h77);
        cycle(1'b0, 1'b1, 12'h200, 8'hC3);
        cycle(1'b0, 1'b1, 12'd3072, 8'h11);
        rd("mem_unmapped", 1'b0, 12'd3072, 8'h00);
        rd("mem_200", 1'b0, 12'h200, 8'hC3);

        // 2: overflow, sticky flag clear on read, ordered drain
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) tx_exp.push_back(8'(i));
            cycle(1'b1, 1'b1, 12'h000, 8'(i));
        end
        rd("stat_ovf", 1'b1, 12'h000, 8'h06);
        idle();
        rd("stat_ovf_clr", 1'b1, 12'h000, 8'h02);
        base = n_pops;
        tx_ready = 1'b1;
        repeat (10) idle();
        chk("drain_count", 16'(n_pops - base), 16'd8);
        chk("drain_tx_valid", {15'h0, tx_valid}, 16'h0000);
        rd("stat_empty", 1'b1, 12'h000, 8'h01);
        tx_ready = 1'b0;

        // 3: push into a full FIFO while it pops
        for (int i = 0; i < 8; i++) begin
            tx_exp.push_back(8'(8'h10 + i));
            cycle(1'b1, 1'b1, 12'h000, 8'(8'h10 + i));
        end
        idle();
        tx_ready = 1'b1;
        tx_exp.push_back(8'hAA);
        cycle(1'b1, 1'b1, 12'h000, 8'hAA);
        repeat (10) idle();
        chk("full_push_drain", 16'(tx_exp.size()), 16'd0);
        rd("stat_no_ovf", 1'b1, 12'h000, 8'h01);
        tx_ready = 1'b0;

        // 4: RX holding register
        rx_valid = 1'b1; rx_data = 8'h3C;
        idle();
        rx_data = 8'h99;
        idle();
        rx_valid = 1'b0;
        chk("rx_ready_full", {15'h0, rx_ready}, 16'h0000);
        rd("stat_rx", 1'b1, 12'h000, 8'h09);
        rd("rx_read", 1'b1, 12'h001, 8'h3C);
        rd("rx_read_held", 1'b1, 12'h001, 8'h00);
        chk("rx_ready_pop", {15'h0, rx_ready}, 16'h0001);
        idle();
        rd("rx_read_empty", 1'b1, 12'h001, 8'h00);
        cycle(1'b1, 1'b1, 12'h001, 8'h55);
        rd("rx_wr_ignored", 1'b1, 12'h001, 8'h00);

        // 5: fetch counter and shadow snapshot
        m1 = 1'b1;
        repeat (12'h1FF) idle();
        m1 = 1'b0;
        rd("cnt_lo", 1'b1, 12'h002, 8'hFF);
        m1 = 1'b1;
        repeat (5) idle();
        m1 = 1'b0;
        rd("cnt_shadow", 1'b1, 12'h003, 8'h01);
        rd("cnt_lo2", 1'b1, 12'h002, 8'h04);
        rd("cnt_shadow_hi_addr", 1'b1, 12'h703, 8'h02);
        rd("other_port", 1'b1, 12'h0A7, 8'hFF);

        // 6: asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) begin
            tx_exp.push_back(8'(8'h41 + i));
            cycle(1'b1, 1'b1, 12'h000, 8'(8'h41 + i));
        end
        tx_ready = 1'b1;
        rd("pre_reset_rd", 1'b0, 12'h123, 8'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        chk("arst_data_in", {8'h00, data_in}, 16'h0000);
        chk("arst_tx_data", {8'h00, tx_data}, 16'h0000);
        tx_exp.delete();
        tx_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        rd("ram_kept_123", 1'b0, 12'h123, 8'h77);
        rd("ram_kept_200", 1'b0, 12'h200, 8'hC3);
        chk("post_rst_rx_ready", {15'h0, rx_ready}, 16'h0001);
        rd("post_rst_status", 1'b1, 12'h000, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
